// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: select codes, FSM states, timing constants.
package div_sequencer_pkg;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned ITER_CNT    = 32;
  localparam int unsigned DIV_LATENCY = 35;

  // Divider select codes
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_ITER = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ITER    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4,
    ST_DZERO   = 3'd5
  } state_e;

  // select is a pure decode of the registered state
  function automatic logic [1:0] sel_decode(input state_e st);
    logic [1:0] sel;
    sel = SEL_HOLD;
    case (st)
      ST_LOAD: sel = SEL_LOAD;
      ST_ITER: sel = SEL_ITER;
      default: sel = SEL_HOLD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Bus between the mult/div unit top and the divide sequencer: CPU request side plus divider side.
interface div_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] rs_in;
  logic [WIDTH-1:0] rt_in;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divider;
  logic [1:0]       select;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, rs_in, rt_in, hi_we, lo_we, wdata, quotient, remainder,
    input  dividend, divider, select, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, rs_in, rt_in, hi_we, lo_we, wdata, quotient, remainder,
    output dividend, divider, select, busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/div_sequencer_hilo_regs.sv
// Architectural HI/LO register pair; divider capture has priority over MTHI/MTLO.
module div_sequencer_hilo_regs
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = div_sequencer_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cap_en,
  input  logic [WIDTH-1:0] cap_hi,
  input  logic [WIDTH-1:0] cap_lo,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // HI register: capture overrides MTHI
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
    end else if (cap_en) begin
      hi <= cap_hi;
    end else if (mthi_en) begin
      hi <= wdata;
    end
  end

  // LO register: capture overrides MTLO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo <= '0;
    end else if (cap_en) begin
      lo <= cap_lo;
    end else if (mtlo_en) begin
      lo <= wdata;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Divide sequencer: latches DIV operands, steps the iterative divider (load, 32 iterates),
// captures quotient/remainder into LO/HI and pulses done; rejects divide-by-zero.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH    = div_sequencer_pkg::WIDTH,
  parameter int unsigned ITER_CNT = div_sequencer_pkg::ITER_CNT
) (
  input logic             clk,
  input logic             reset_n,
  div_sequencer_if.slave  bus
);

  localparam int unsigned CW = $clog2(ITER_CNT + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divider_q;
  logic             accept;
  logic             mt_ok;

  assign accept = (state_q == ST_IDLE) && bus.start && (bus.rt_in != '0);
  assign mt_ok  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_DZERO);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.rt_in != '0) ? ST_LOAD : ST_DZERO;
        end
      end
      ST_LOAD:    state_d = ST_ITER;
      ST_ITER:    state_d = (cnt_q == CW'(1)) ? ST_CAPTURE : ST_ITER;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      ST_DZERO:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Iterate counter: loaded in LOAD, counts down once per iterate edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_q == ST_LOAD) begin
      cnt_q <= CW'(ITER_CNT);
    end else if (state_q == ST_ITER) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Operand latch: only on an accepted non-zero-divisor request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dividend_q <= '0;
      divider_q  <= '0;
    end else if (accept) begin
      dividend_q <= bus.rs_in;
      divider_q  <= bus.rt_in;
    end
  end

  assign bus.dividend = dividend_q;
  assign bus.divider  = divider_q;
  assign bus.select   = sel_decode(state_q);
  assign bus.busy     = (state_q == ST_LOAD) || (state_q == ST_ITER) || (state_q == ST_CAPTURE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.div_zero = (state_q == ST_DZERO);

  div_sequencer_hilo_regs #(
    .WIDTH (WIDTH)
  ) u_hilo (
    .clk     (clk),
    .reset_n (reset_n),
    .cap_en  (state_q == ST_CAPTURE),
    .cap_hi  (bus.remainder),
    .cap_lo  (bus.quotient),
    .mthi_en (bus.hi_we && mt_ok),
    .mtlo_en (bus.lo_we && mt_ok),
    .wdata   (bus.wdata),
    .hi      (bus.hi),
    .lo      (bus.lo)
  );

endmodule
